addsub_accum: RTL and testbench
===============================

Name: addsub_accum

Overview:
- Downstream consumer of the signed add/subtract stage.
- Takes that stage's N+1-bit Sum/Sub results, selects one per sample and accumulates M samples into a saturating ACC_W-bit signed register.
- Presents the final total to the next stage with a valid/ready handshake.
- Provides windowed summation of add/sub results without back-to-back software reads.

Parameters:
- N, 4, operand width of the upstream add/sub stage; result inputs are N+1 bits signed.
- M, 8, samples per accumulation window (M >= 1).
- ACC_W, 7, accumulator width in bits, signed; ACC_W >= N+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new window; honoured only in IDLE.
- in_valid  input  1  Sum/Sub/sel carry a sample this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- sel  input  1  0 = take Sum, 1 = take Sub.
- Sum  input  N+1  signed sum result from the upstream stage.
- Sub  input  N+1  signed difference result from the upstream stage.
- Acc  output  ACC_W  signed running/final accumulator value.
- ovf  output  1  sticky: saturation occurred in the current window.
- out_valid  output  1  Acc holds the completed window total.
- out_ready  input  1  downstream consumes the total.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous on rst_n=0. State=IDLE, Acc=0, ovf=0, count=0, out_valid=0, in_ready=0, busy=0. Reset mid-window discards partial sum; no output is produced.
- States: IDLE, RUN, HOLD. All outputs are registered or decoded from the state register; no combinational path from in_valid to in_ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 at an edge: Acc<=0, ovf<=0, count<=0, next=RUN.
  - start=0: stay in IDLE; Acc keeps the last total.
- RUN:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready at an edge.
  - On accept: operand = sel ? Sub : Sum, sign-extended to ACC_W; Acc <= sat(Acc + operand); count <= count+1.
  - Accept with count==M-1: next=HOLD, with the final Acc written on the same edge.
  - in_valid=0 cycles (bubbles) change nothing.
  - start is ignored in RUN.
- HOLD:
  - out_valid=1, in_ready=0, Acc and ovf stable.
  - out_ready=1 at an edge: next=IDLE, out_valid falls.
  - out_ready held low: stay in HOLD indefinitely with no change.
  - start is ignored in HOLD.
- Latency:
  - out_valid rises one cycle after the edge accepting the M-th sample.
  - Minimum window = 1 (start) + M (samples) cycles to HOLD.
  - Minimum return to IDLE = 1 further cycle.
- Arithmetic:
  - Add in ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max and set ovf.
  - Below -2^(ACC_W-1): clamp to min and set ovf.
  - ovf is sticky until the next start.
  - After saturation, accumulation continues from the clamped value.
- count: width clog2(M)+1, never exceeds M-1 in RUN. M=1 means a single accept goes straight to HOLD.
- Simultaneous events:
  - out_ready with start in HOLD: handshake completes to IDLE; start is not latched.
  - in_valid outside RUN: ignored, no data loss reported.

Decomposition:
- Shared include addsub_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2;
  - SEL_SUM=1'b0 and SEL_SUB=1'b1.
- One sub-module, sat_add, is natural:
  - parameter W;
  - signed W-bit acc and operand in, W-bit clamped result and sat flag out;
  - purely combinational, instanced once.

Test Plan:
1. Default parameters; start; 8 samples sel=0, Sum=5 back-to-back -> Acc=40, ovf=0, out_valid high exactly one cycle after the 8th accept; out_ready=1 returns to IDLE next cycle.
2. Alternate sel=0/1 with Sum=7, Sub=-3 for 8 samples, random bubbles on in_valid -> Acc=16, ovf=0; in_ready high throughout RUN; bubbles do not advance count.
3. Saturation: 8 samples Sum=15 -> Acc=63, ovf=1. Then 8 samples Sub=-16 -> Acc=-64, ovf=1. Next window with Sum=1 x8 -> Acc=8, ovf=0 (sticky cleared by start).
4. Backpressure: out_ready=0 for 5 cycles after completion -> out_valid, Acc, ovf stable; in_valid and start pulses ignored; out_ready=1 -> IDLE.
5. Reset mid-window: after 3 accepts of Sum=4, pulse rst_n=0 between edges -> Acc=0, state IDLE, busy=0 immediately (asynchronous); no out_valid ever asserted.
6. M=1 override: start, one sample Sub=-9 -> HOLD next cycle with Acc=-9; start asserted in RUN and HOLD has no effect.

Source files
------------

// File: rtl/addsub_accum_pkg.sv
// Shared definitions for the add/sub accumulator: FSM encodings and sample selector.
package addsub_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic SEL_SUM = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/addsub_accum_sat_add.sv
// Combinational signed W-bit add that clamps to the representable range.
module sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                sat
);

    logic [W:0] wide;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        sat  = wide[W] ^ wide[W-1];
        if (!sat)
            y = wide[W-1:0];
        else if (wide[W])
            y = {1'b1, {(W-1){1'b0}}};
        else
            y = {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/addsub_accum.sv
// Windowed saturating accumulator of add/sub stage results with valid/ready output.
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int ACC_W = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sel,
    input  logic signed [N:0]       Sum,
    input  logic signed [N:0]       Sub,
    output logic signed [ACC_W-1:0] Acc,
    output logic                    ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int CNT_W = $clog2(M) + 1;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic signed [N:0]       pick;
    logic signed [ACC_W-1:0] operand;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sat;

    // Handshake flags are pure state decodes, so in_valid never reaches in_ready.
    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    assign pick    = (sel == SEL_SUB) ? Sub : Sum;
    assign operand = ACC_W'(pick);

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (Acc),
        .b   (operand),
        .y   (acc_next),
        .sat (sat)
    );

    // Window FSM: clear on start, accumulate M accepts, hold total until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            Acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        Acc   <= '0;
                        ovf   <= 1'b0;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        Acc   <= acc_next;
                        count <= count + 1'b1;
                        if (sat)
                            ovf <= 1'b1;
                        if (count == CNT_W'(M - 1))
                            state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_accum.sv
// Randomized self-checking bench for addsub_accum with an integer reference model.
module tb_addsub_accum;

    localparam int N     = 4;
    localparam int M     = 8;
    localparam int ACC_W = 7;
    localparam int AMAX  = (1 << (ACC_W - 1)) - 1;
    localparam int AMIN  = -(1 << (ACC_W - 1));

    logic clk;
    logic rst_n;

    // default-parameter instance
    logic                    start, in_valid, in_ready, sel, out_valid, out_ready, busy, ovf;
    logic signed [N:0]       sum, sub;
    logic signed [ACC_W-1:0] acc;

    // M=1 instance
    logic                    start1, in_valid1, in_ready1, sel1, out_valid1, out_ready1, busy1, ovf1;
    logic signed [N:0]       sum1, sub1;
    logic signed [ACC_W-1:0] acc1;

    int checks = 0;
    int errors = 0;

    int s_sum [M];
    int s_sub [M];
    bit s_sel [M];

    int model_acc;
    bit model_ovf;

    addsub_accum #(.N(N), .M(M), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .Sum(sum), .Sub(sub), .Acc(acc), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    addsub_accum #(.N(N), .M(1), .ACC_W(ACC_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sel(sel1), .Sum(sum1), .Sub(sub1), .Acc(acc1), .ovf(ovf1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: windowed sum with clamping after every sample, sticky overflow.
    function automatic void model_add(input int v);
        model_acc = model_acc + v;
        if (model_acc > AMAX) begin
            model_acc = AMAX;
            model_ovf = 1'b1;
        end else if (model_acc < AMIN) begin
            model_acc = AMIN;
            model_ovf = 1'b1;
        end
    endfunction

    // Runs one full window from s_* tables; bub = percent chance of a bubble cycle.
    task automatic run_window(input string name, input int bub);
        int i;
        int budget;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_acc = 0;
        model_ovf = 1'b0;
        chk({name, "_busy"}, busy, 1);
        chk({name, "_clr_acc"}, acc, 0);
        chk({name, "_clr_ovf"}, ovf, 0);
        i = 0;
        budget = 200;
        while (i < M && budget > 0) begin
            budget--;
            chk({name, "_in_ready"}, in_ready, 1);
            chk({name, "_no_outv"}, out_valid, 0);
            in_valid = ($urandom_range(99) >= bub);
            sel = s_sel[i];
            sum = (N+1)'(s_sum[i]);
            sub = (N+1)'(s_sub[i]);
            tick();
            if (in_valid) begin
                model_add(s_sel[i] ? s_sub[i] : s_sum[i]);
                i++;
            end
            chk({name, "_run_acc"}, acc, model_acc);
        end
        in_valid = 1'b0;
        if (i != M) chk({name, "_timeout"}, i, M);
        chk({name, "_outv"}, out_valid, 1);
        chk({name, "_in_ready_hold"}, in_ready, 0);
        chk({name, "_ovf"}, ovf, model_ovf);
    endtask

    // Holds out_ready low for 'hold' cycles with noise on start/in_valid, then drains.
    task automatic drain(input string name, input int hold);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(1));
            in_valid = 1'($urandom_range(1));
            sel = 1'($urandom_range(1));
            sum = (N+1)'($urandom);
            sub = (N+1)'($urandom);
            tick();
            chk({name, "_hold_outv"}, out_valid, 1);
            chk({name, "_hold_acc"}, acc, model_acc);
            chk({name, "_hold_ovf"}, ovf, model_ovf);
        end
        out_ready = 1'b1;
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        chk({name, "_drop_outv"}, out_valid, 0);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_acc"}, acc, model_acc);
        out_ready = 1'b0;
        start = 1'b0;
        tick();
        chk({name, "_no_latch"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {start, in_valid, sel, out_ready} = '0;
        {start1, in_valid1, sel1, out_ready1} = '0;
        sum = '0; sub = '0; sum1 = '0; sub1 = '0;
        tick();
        tick();
        chk("rst_acc", acc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outv", out_valid, 0);
        rst_n = 1'b1;
        tick();

        // 1: constant Sum=5, back-to-back
        for (int k = 0; k < M; k++) begin s_sum[k] = 5; s_sub[k] = -1; s_sel[k] = 0; end
        run_window("t1", 0);
        chk("t1_total", acc, 40);
        drain("t1", 0);

        // 2: alternate Sum=7 / Sub=-3 with bubbles
        for (int k = 0; k < M; k++) begin s_sum[k] = 7; s_sub[k] = -3; s_sel[k] = k[0]; end
        run_window("t2", 30);
        chk("t2_total", acc, 16);
        drain("t2", 0);

        // 3: positive then negative saturation, then sticky cleared
        for (int k = 0; k < M; k++) begin s_sum[k] = 15; s_sub[k] = 0; s_sel[k] = 0; end
        run_window("t3a", 0);
        chk("t3a_total", acc, 63);
        chk("t3a_ovf1", ovf, 1);
        drain("t3a", 0);
        for (int k = 0; k < M; k++) begin s_sum[k] = 0; s_sub[k] = -16; s_sel[k] = 1; end
        run_window("t3b", 0);
        chk("t3b_total", acc, -64);
        drain("t3b", 0);
        for (int k = 0; k < M; k++) begin s_sum[k] = 1; s_sub[k] = 0; s_sel[k] = 0; end
        run_window("t3c", 0);
        chk("t3c_total", acc, 8);
        chk("t3c_ovf0", ovf, 0);
        drain("t3c", 0);

        // 4: random windows with backpressure
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < M; k++) begin
                s_sum[k] = $urandom_range(31) - 16;
                s_sub[k] = $urandom_range(31) - 16;
                s_sel[k] = 1'($urandom_range(1));
            end
            run_window("t4", 25);
            drain("t4", 5);
        end

        // 5: asynchronous reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; sel = 1'b0; sum = 5'sd4;
            tick();
        end
        in_valid = 1'b0;
        chk("t5_partial", acc, 12);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_acc", acc, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            tick();
            chk("t5_no_outv", out_valid, 0);
            chk("t5_idle", busy, 0);
        end
        in_valid = 1'b0;

        // 6: M=1 instance, start ignored in RUN and HOLD
        start1 = 1'b1;
        tick();
        chk("t6_run", in_ready1, 1);
        in_valid1 = 1'b1; sel1 = 1'b1; sub1 = -5'sd9; sum1 = 5'sd3;
        tick();
        in_valid1 = 1'b0;
        chk("t6_outv", out_valid1, 1);
        chk("t6_acc", acc1, -9);
        chk("t6_ovf", ovf1, 0);
        tick();
        chk("t6_hold_outv", out_valid1, 1);
        chk("t6_hold_acc", acc1, -9);
        start1 = 1'b0;
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("t6_idle", busy1, 0);
        chk("t6_keep_acc", acc1, -9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
